// File: rtl/lfsr_interval_timer.sv
// lfsr_interval_timer: Galois-LFSR base period cascaded with a programmable down-counter
module lfsr_interval_timer #(
  parameter int             W     = 16,
  parameter logic [W-1:0]   TAPS  = 16'h002D,
  parameter logic [W-1:0]   SEED  = 16'hFFFF,
  parameter logic [W-1:0]   TERM  = 16'h6DB6,
  parameter int             CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] remaining_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
  logic mode_q, mode_d, tick_q, tick_d, done_q, done_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      rem_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      lfsr_d = SEED;
      if (start_i && count_i != '0) begin
        state_d = RUN;
        rem_d   = count_i;
        cnt_d   = count_i;
        mode_d  = mode_i;
      end else if (start_i) begin
        done_d = 1'b1;
      end
    end else if (stop_i) begin
      state_d = IDLE;
      lfsr_d  = SEED;
      rem_d   = '0;
    end else if (start_i) begin
      // a restart with a zero count behaves like a zero-count start from idle
      lfsr_d = SEED;
      rem_d  = count_i;
      if (count_i != '0) begin
        cnt_d  = count_i;
        mode_d = mode_i;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (!pause_i) begin
      if (lfsr_q == TERM) begin
        lfsr_d = SEED;
        tick_d = 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          rem_d   = mode_q ? cnt_q : '0;
          state_d = mode_q ? RUN : IDLE;
        end
      end else begin
        lfsr_d = {lfsr_q[W-2:0], 1'b0} ^ (lfsr_q[W-1] ? TAPS : '0);
      end
    end
  end
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign busy_o      = state_q == RUN;
  assign remaining_o = rem_q;
endmodule
